// File: rtl/acc_pkg.sv
// Shared types and widths for the pixel stream accelerator.
package acc_pkg;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 16;

  typedef enum logic [1:0] {
    INVERT  = 2'b00,
    THRESH  = 2'b01,
    PASS    = 2'b10,
    ADD_SAT = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StCapt,
    StWrite,
    StDrain,
    StDone
  } state_t;

endpackage

// File: rtl/pixel_lane_xform.sv
// Combinational point operation on one 8-bit pixel lane; clip flags a saturated add.
module pixel_lane_xform
  import acc_pkg::*;
(
  input  logic [PIX_W-1:0] p,
  input  logic [PIX_W-1:0] param,
  input  logic [1:0]       mode,
  output logic [PIX_W-1:0] q,
  output logic             clip
);

  logic [PIX_W:0] w_sum;

  always_comb begin
    w_sum = {1'b0, p} + {1'b0, param};
    q     = p;
    clip  = 1'b0;
    case (mode_t'(mode))
      INVERT:  q = ~p;
      THRESH:  q = (p >= param) ? '1 : '0;
      PASS:    q = p;
      ADD_SAT: begin
        q    = w_sum[PIX_W] ? '1 : w_sum[PIX_W-1:0];
        clip = w_sum[PIX_W];
      end
      default: q = p;
    endcase
  end

endmodule

// File: rtl/pixel_stream_acc.sv
// Streams an image word by word from src_base to dst_base through a per-lane point
// operation, overlapping the read of word k with the write of word k-1.
module pixel_stream_acc
  import acc_pkg::*;
#(
  parameter int unsigned IMG_W        = 352,
  parameter int unsigned IMG_H        = 288,
  parameter int unsigned PIX_PER_WORD = 4,
  localparam int unsigned N_WORDS     = IMG_W * IMG_H / PIX_PER_WORD,
  localparam int unsigned CNT_W       = $clog2(N_WORDS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [7:0]        param,
  input  logic [15:0]       src_base,
  input  logic [15:0]       dst_base,
  output logic [15:0]       addr,
  input  logic [31:0]       dataR,
  output logic [31:0]       dataW,
  output logic              en,
  output logic              we,
  output logic              finish,
  output logic [CNT_W+1:0]  sat_count
);

  localparam int unsigned SAT_W  = CNT_W + 2;
  localparam int unsigned CLIP_W = $clog2(PIX_PER_WORD + 1);

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_k;
  logic [1:0]          r_mode;
  logic [PIX_W-1:0]    r_param;
  logic [ADDR_W-1:0]   r_src, r_dst;
  logic [WORD_W-1:0]   r_out;
  logic [SAT_W-1:0]    r_sat;

  logic                w_accept, w_capture;
  logic [WORD_W-1:0]   w_word;
  logic [PIX_PER_WORD-1:0] w_clip;
  logic [CLIP_W-1:0]   w_clip_cnt;

  for (genvar i = 0; i < PIX_PER_WORD; i++) begin : g_lane
    pixel_lane_xform u_lane (
      .p     (dataR[i*PIX_W +: PIX_W]),
      .param (r_param),
      .mode  (r_mode),
      .q     (w_word[i*PIX_W +: PIX_W]),
      .clip  (w_clip[i])
    );
  end

  always_comb begin
    w_clip_cnt = '0;
    for (int i = 0; i < PIX_PER_WORD; i++) begin
      w_clip_cnt = w_clip_cnt + CLIP_W'(w_clip[i]);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    addr        = '0;
    dataW       = '0;
    en          = 1'b0;
    we          = 1'b0;
    finish      = 1'b0;
    case (r_state)
      StIdle: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = StRead;
        end
      end
      StRead: begin
        en          = 1'b1;
        addr        = r_src + ADDR_W'(r_k);
        w_state_nxt = (r_k == '0) ? StCapt : StWrite;
      end
      StCapt: begin
        w_capture   = 1'b1;
        w_state_nxt = (N_WORDS == 1) ? StDrain : StRead;
      end
      StWrite: begin
        // Write word k-1 while capturing word k from the read issued last cycle.
        en          = 1'b1;
        we          = 1'b1;
        addr        = r_dst + ADDR_W'(r_k) - ADDR_W'(1);
        dataW       = r_out;
        w_capture   = 1'b1;
        w_state_nxt = (32'(r_k) + 32'd1 < N_WORDS) ? StRead : StDrain;
      end
      StDrain: begin
        en          = 1'b1;
        we          = 1'b1;
        addr        = r_dst + ADDR_W'(N_WORDS - 1);
        dataW       = r_out;
        w_state_nxt = StDone;
      end
      StDone: begin
        finish = 1'b1;
        if (!start) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= StIdle;
      r_k     <= '0;
      r_mode  <= '0;
      r_param <= '0;
      r_src   <= '0;
      r_dst   <= '0;
      r_out   <= '0;
      r_sat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_mode  <= mode;
        r_param <= param;
        r_src   <= src_base;
        r_dst   <= dst_base;
        r_k     <= '0;
        r_sat   <= '0;
      end
      if (w_capture) begin
        r_out <= w_word;
        r_k   <= r_k + CNT_W'(1);
        r_sat <= r_sat + SAT_W'(w_clip_cnt);
      end
    end
  end

  assign sat_count = r_sat;

endmodule

// File: tb/tb_pixel_stream_acc.sv
// Scoreboard bench: stimulus queues expected reads, writes and run results; a monitor checks them.
module tb_pixel_stream_acc;
  import acc_pkg::*;

  localparam int unsigned NW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [7:0]  param = 8'h00;
  logic [15:0] src_base = 16'h0000;
  logic [15:0] dst_base = 16'h0000;
  logic [15:0] addr;
  logic [31:0] dataR = 32'h0;
  logic [31:0] dataW;
  logic        en, we, finish;
  logic [4:0]  sat_count;

  always #5 clk = ~clk;

  pixel_stream_acc #(
    .IMG_W        (8),
    .IMG_H        (2),
    .PIX_PER_WORD (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .param     (param),
    .src_base  (src_base),
    .dst_base  (dst_base),
    .addr      (addr),
    .dataR     (dataR),
    .dataW     (dataW),
    .en        (en),
    .we        (we),
    .finish    (finish),
    .sat_count (sat_count)
  );

  // Synchronous-read memory with a bench-side preload port.
  logic [31:0] mem [65536];
  logic        ld_en = 1'b0;
  logic [15:0] ld_addr = 16'h0;
  logic [31:0] ld_data = 32'h0;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (en && we) mem[addr] <= dataW;
    if (en && !we) dataR <= mem[addr];
  end

  typedef struct packed {
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         wq[$];
  logic [15:0] rq[$];
  int          satq[$];

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   acc_cyc = -100;
  logic rst_q = 1'b1;
  bit   end_flag = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    rst_q = reset;
  end

  initial begin : monitor
    bit   armed;
    logic fin_q;
    int   n_rd, n_wr, req_sat;
    wr_t  w;
    armed = 1'b0;
    fin_q = 1'b0;
    n_rd  = 0;
    n_wr  = 0;
    forever begin
      @(negedge clk);
      if (!rst_q) begin
        check("rst_en", 32'(en), 0);
        check("rst_we", 32'(we), 0);
        check("rst_finish", 32'(finish), 0);
        check("rst_addr", 32'(addr), 0);
        check("rst_dataW", dataW, 0);
        check("rst_sat_count", 32'(sat_count), 0);
        armed = 1'b0;
      end
      if (cyc == acc_cyc && !armed && satq.size() > 0) begin
        armed = 1'b1;
        n_rd  = 0;
        n_wr  = 0;
      end
      if (en && !we) begin
        n_rd++;
        if (rq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_read: addr %h, no read required", addr);
        end else begin
          check("read_addr", 32'(addr), 32'(rq.pop_front()));
        end
      end
      if (en && we) begin
        n_wr++;
        if (wq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: addr %h data %h, no write required", addr, dataW);
        end else begin
          w = wq.pop_front();
          check("write_addr", 32'(addr), 32'(w.a));
          check("write_data", dataW, w.d);
        end
      end
      if (finish) check("no_access_in_done", 32'(en), 0);
      if (finish && !fin_q) begin
        if (armed) begin
          req_sat = satq.pop_front();
          check("run_cycles", cyc - acc_cyc, 2 * NW + 1);
          check("run_reads", n_rd, NW);
          check("run_writes", n_wr, NW);
          check("sat_count", 32'(sat_count), req_sat);
          armed = 1'b0;
        end else begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_finish: finish=1, required 0");
        end
      end
      if (armed && (cyc - acc_cyc) > 40) begin
        n_vec++;
        n_err++;
        $display("FAIL run_timeout: finish=0 after %0d cycles, required 1", cyc - acc_cyc);
        void'(satq.pop_front());
        armed = 1'b0;
      end
      fin_q = finish;
      if (end_flag) begin
        check("reads_outstanding", rq.size(), 0);
        check("writes_outstanding", wq.size(), 0);
        check("runs_outstanding", satq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
      end
    end
  end

  task automatic preload(input logic [15:0] base, input logic [0:3][31:0] w);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = base + 16'(i);
      ld_data = w[i];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic run(input logic [1:0] m, input logic [7:0] p, input logic [15:0] s,
                     input logic [15:0] d, input logic [0:3][31:0] src,
                     input logic [0:3][31:0] res, input int sat, input bit hold);
    wr_t e;
    preload(s, src);
    for (int i = 0; i < 4; i++) begin
      rq.push_back(s + 16'(i));
      e.a = d + 16'(i);
      e.d = res[i];
      wq.push_back(e);
    end
    satq.push_back(sat);
    @(negedge clk);
    mode     = m;
    param    = p;
    src_base = s;
    dst_base = d;
    start    = 1'b1;
    acc_cyc  = cyc + 1;
    @(posedge clk);
    #1;
    // Scramble the latched inputs to show they are ignored mid-run.
    mode     = ~m;
    param    = ~p;
    src_base = ~s;
    dst_base = ~d;
    if (!hold) start = 1'b0;
    for (int t = 0; t < 60 && !finish; t++) @(negedge clk);
    if (hold) begin
      repeat (5) @(negedge clk);
      start = 1'b0;
    end
    for (int t = 0; t < 10 && finish; t++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic abort_run();
    wr_t e;
    rq.push_back(16'h0000);
    rq.push_back(16'h0001);
    rq.push_back(16'h0002);
    e.a = 16'h0600;
    e.d = 32'hFF00EF10;
    wq.push_back(e);
    @(negedge clk);
    mode     = INVERT;
    param    = 8'h00;
    src_base = 16'h0000;
    dst_base = 16'h0600;
    start    = 1'b1;
    acc_cyc  = cyc + 1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run(INVERT, 8'h00, 16'h0000, 16'h0100,
        {32'h00FF10EF, 32'h12345678, 32'h80808080, 32'hFFFFFFFF},
        {32'hFF00EF10, 32'hEDCBA987, 32'h7F7F7F7F, 32'h00000000}, 0, 1'b0);
    run(THRESH, 8'h80, 16'h0010, 16'h0200,
        {32'h7F80FF00, 32'h00000000, 32'h80818283, 32'h7E7F0102},
        {32'h00FFFF00, 32'h00000000, 32'hFFFFFFFF, 32'h00000000}, 0, 1'b0);
    run(THRESH, 8'h00, 16'h0010, 16'h0300,
        {32'h7F80FF00, 32'h00000000, 32'h80818283, 32'h7E7F0102},
        {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}, 0, 1'b0);
    run(ADD_SAT, 8'h10, 16'h0020, 16'h0400,
        {32'hF5F0EF00, 32'hF5F0EF00, 32'hF5F0EF00, 32'hF5F0EF00},
        {32'hFFFFFF10, 32'hFFFFFF10, 32'hFFFFFF10, 32'hFFFFFF10}, 8, 1'b0);
    abort_run();
    run(INVERT, 8'h00, 16'h0000, 16'h0700,
        {32'h00FF10EF, 32'h12345678, 32'h80808080, 32'hFFFFFFFF},
        {32'hFF00EF10, 32'hEDCBA987, 32'h7F7F7F7F, 32'h00000000}, 0, 1'b0);
    run(PASS, 8'hFF, 16'hFFFE, 16'h0500,
        {32'hA1B2C3D4, 32'h11223344, 32'h00FF10EF, 32'h12345678},
        {32'hA1B2C3D4, 32'h11223344, 32'h00FF10EF, 32'h12345678}, 0, 1'b0);
    run(ADD_SAT, 8'h10, 16'h0020, 16'h0800,
        {32'hF5F0EF00, 32'hF5F0EF00, 32'hF5F0EF00, 32'hF5F0EF00},
        {32'hFFFFFF10, 32'hFFFFFF10, 32'hFFFFFF10, 32'hFFFFFF10}, 8, 1'b1);
    run(ADD_SAT, 8'h0C, 16'h0020, 16'h0900,
        {32'hF5F0EF00, 32'hF5F0EF00, 32'hF5F0EF00, 32'hF5F0EF00},
        {32'hFFFCFB0C, 32'hFFFCFB0C, 32'hFFFCFB0C, 32'hFFFCFB0C}, 4, 1'b0);

    repeat (3) @(negedge clk);
    end_flag = 1'b1;
    repeat (10) @(negedge clk);
    $display("FAIL summary_missing: monitor did not end the run");
    $fatal(1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
